// File: rtl/melody_sequencer.sv
// Melody sequencer: arbitrates the tone generator between a looping alarm and a one-shot chime.
// Optional MELODY_GAP_EN inserts GAP_CYCLES of silence after every note.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_req,
    input  logic       chime_req,
    input  logic       stop,
    output logic [5:0] music,
    output logic       sound_en,
    output logic       busy,
    output logic [1:0] owner,
    output logic       done
);

`ifdef MELODY_GAP_EN
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_CHIME = 2'b01;
    localparam logic [1:0] OWN_ALARM = 2'b10;
    localparam logic [5:0] REST      = 6'd63;

    // One counter serves both beats and gaps, so size it for the longer of the two.
    localparam int MAX_CNT = (15 * BEAT_CYCLES > GAP_CYCLES) ? 15 * BEAT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    function automatic logic [9:0] rom_entry(input logic alarm, input logic [2:0] idx);
        logic [9:0] e;
        case ({alarm, idx})
            4'b0_000: e = {6'd12, 4'd2};
            4'b0_001: e = {6'd16, 4'd2};
            4'b0_010: e = {6'd19, 4'd2};
            4'b0_011: e = {6'd24, 4'd4};
            4'b1_000: e = {6'd24, 4'd1};
            4'b1_001: e = {6'd21, 4'd1};
            4'b1_010: e = {6'd24, 4'd1};
            4'b1_011: e = {6'd21, 4'd1};
            default:  e = 10'd0;
        endcase
        return e;
    endfunction

    state_t           state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             alarm_armed;
    logic [9:0]       entry;
    logic [5:0]       note;
    logic [3:0]       dur;
    logic             alarm_start;
    logic             chime_start;
    logic             abort;

    assign entry       = rom_entry(owner[1], idx);
    assign note        = entry[9:4];
    assign dur         = entry[3:0];
    assign alarm_start = alarm_req && alarm_armed && (owner != OWN_ALARM);
    assign chime_start = chime_req && (owner == OWN_NONE) && !alarm_start;
    assign abort       = stop || ((owner == OWN_ALARM) && !alarm_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 3'd0;
            cnt         <= '0;
            alarm_armed <= 1'b1;
            music       <= REST;
            sound_en    <= 1'b0;
            busy        <= 1'b0;
            owner       <= OWN_NONE;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            // A held alarm stays silenced after stop until the request is seen low.
            if (stop && alarm_req)
                alarm_armed <= 1'b0;
            else if (!alarm_req)
                alarm_armed <= 1'b1;

            if (abort) begin
                state    <= IDLE;
                idx      <= 3'd0;
                cnt      <= '0;
                music    <= REST;
                sound_en <= 1'b0;
                busy     <= 1'b0;
                owner    <= OWN_NONE;
            end else if (alarm_start || chime_start) begin
                state    <= LOAD;
                idx      <= 3'd0;
                sound_en <= 1'b0;
                busy     <= 1'b1;
                owner    <= alarm_start ? OWN_ALARM : OWN_CHIME;
            end else begin
                case (state)
                    LOAD: begin
                        if (dur == 4'd0) begin
                            if (owner == OWN_ALARM) begin
                                idx <= 3'd0;
                            end else begin
                                state <= IDLE;
                                idx   <= 3'd0;
                                music <= REST;
                                busy  <= 1'b0;
                                owner <= OWN_NONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            music    <= note;
                            sound_en <= 1'b1;
                            cnt      <= CNT_W'(int'(dur) * BEAT_CYCLES - 1);
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (cnt == '0) begin
                            sound_en <= 1'b0;
                            idx      <= idx + 3'd1;
`ifdef MELODY_GAP_EN
                            cnt      <= CNT_W'(GAP_CYCLES - 1);
                            state    <= GAP;
`else
                            state    <= LOAD;
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`ifdef MELODY_GAP_EN
                    GAP: begin
                        if (cnt == '0)
                            state <= LOAD;
                        else
                            cnt <= cnt - 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a per-cycle scoreboard of expected outputs.
module tb_melody_sequencer;

    localparam int BEAT = 4;
    localparam int GAPC = 2;
`ifdef MELODY_GAP_EN
    localparam int G = GAPC;
`else
    localparam int G = 0;
`endif

    localparam logic [1:0] C = 2'b01;
    localparam logic [1:0] A = 2'b10;
    localparam int CN[4] = '{12, 16, 19, 24};
    localparam int CD[4] = '{2, 2, 2, 4};
    localparam int AN[4] = '{24, 21, 24, 21};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alarm_req = 1'b0;
    logic       chime_req = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] music;
    logic       sound_en;
    logic       busy;
    logic [1:0] owner;
    logic       done;

    melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .rst_n(rst_n), .alarm_req(alarm_req), .chime_req(chime_req),
        .stop(stop), .music(music), .sound_en(sound_en), .busy(busy),
        .owner(owner), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] music;
        logic       se;
        logic       busy;
        logic [1:0] owner;
        logic       done;
        logic       chk_music;
    } exp_t;

    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    string tag = "init";

    task automatic push(input logic [5:0] m, input logic se, input logic b,
                        input logic [1:0] o, input logic d, input logic cm, input int n);
        exp_t e;
        e.music = m; e.se = se; e.busy = b; e.owner = o; e.done = d; e.chk_music = cm;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        push(6'd63, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, n);
    endtask

    // Silent active cycles (LOAD or GAP): music value is not checked here.
    task automatic push_sil(input logic [1:0] o, input int n);
        push(6'd0, 1'b0, 1'b1, o, 1'b0, 1'b0, n);
    endtask

    task automatic push_note(input logic [1:0] o, input int nt, input int n);
        push(6'(nt), 1'b1, 1'b1, o, 1'b0, 1'b1, n);
    endtask

    task automatic exp_chime();
        push_sil(C, 1);
        for (int i = 0; i < 4; i++) begin
            push_note(C, CN[i], CD[i] * BEAT);
            push_sil(C, G + 1);
        end
        push(6'd63, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1);
    endtask

    task automatic exp_alarm_loops(input int loops);
        push_sil(A, 1);
        for (int l = 0; l < loops; l++) begin
            for (int i = 0; i < 4; i++) begin
                push_note(A, AN[i], BEAT);
                push_sil(A, G + 1);
            end
            push_sil(A, 1);
        end
    endtask

    // Drive inputs for the current cycle, check this cycle's outputs, advance one cycle.
    task automatic cycle_chk(input logic a, input logic c, input logic s);
        exp_t e;
        exp_t o;
        alarm_req = a; chime_req = c; stop = s;
        @(negedge clk);
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL %s: no expected entry, observed music=%0d se=%0b", tag, music, sound_en);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o.music = e.chk_music ? music : e.music;
            o.se = sound_en; o.busy = busy; o.owner = owner; o.done = done;
            o.chk_music = e.chk_music;
            vectors++;
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed music=%0d se=%0b busy=%0b owner=%b done=%0b, expected music=%0d(chk %0b) se=%0b busy=%0b owner=%b done=%0b",
                       tag, music, sound_en, busy, owner, done,
                       e.music, e.chk_music, e.se, e.busy, e.owner, e.done);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n, input logic a, input logic c, input logic s);
        for (int i = 0; i < n; i++) cycle_chk(a, c, s);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        tag = "reset";
        push_idle(2);
        run_n(2, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        tag = "chime";
        push_idle(1);
        cycle_chk(1'b0, 1'b1, 1'b0);
        exp_chime();
        run_n(exp_q.size(), 1'b0, 1'b0, 1'b0);
        push_idle(2);
        run_n(2, 1'b0, 1'b0, 1'b0);

        tag = "alarm_loop";
        push_idle(1);
        cycle_chk(1'b1, 1'b0, 1'b0);
        exp_alarm_loops(2);
        run_n(exp_q.size(), 1'b1, 1'b0, 1'b0);
        push_note(A, 24, 1);
        cycle_chk(1'b0, 1'b0, 1'b0);
        push_idle(2);
        run_n(2, 1'b0, 1'b0, 1'b0);

        tag = "preempt";
        push_idle(1);
        cycle_chk(1'b0, 1'b1, 1'b0);
        push_sil(C, 1);
        push_note(C, 12, 8);
        push_sil(C, G + 1);
        push_note(C, 16, 3);
        run_n(exp_q.size(), 1'b0, 1'b0, 1'b0);
        push_note(C, 16, 1);
        cycle_chk(1'b1, 1'b0, 1'b0);
        push_sil(A, 1);
        push_note(A, 24, BEAT);
        push_sil(A, G + 1);
        push_note(A, 21, 1);
        run_n(exp_q.size() - 1, 1'b1, 1'b0, 1'b0);
        cycle_chk(1'b0, 1'b0, 1'b0);
        push_idle(2);
        run_n(2, 1'b0, 1'b0, 1'b0);

        tag = "stop_held";
        push_idle(1);
        cycle_chk(1'b1, 1'b0, 1'b0);
        push_sil(A, 1);
        push_note(A, 24, 2);
        run_n(exp_q.size(), 1'b1, 1'b0, 1'b0);
        push_note(A, 24, 1);
        cycle_chk(1'b1, 1'b0, 1'b1);
        push_idle(5);
        run_n(5, 1'b1, 1'b0, 1'b0);
        tag = "rearm";
        push_idle(2);
        cycle_chk(1'b0, 1'b0, 1'b0);
        cycle_chk(1'b1, 1'b0, 1'b0);
        push_sil(A, 1);
        push_note(A, 24, 2);
        run_n(exp_q.size(), 1'b1, 1'b0, 1'b0);
        tag = "chime_in_alarm";
        push_note(A, 24, 1);
        cycle_chk(1'b1, 1'b1, 1'b0);
        push_note(A, 24, 1);
        push_sil(A, G + 1);
        push_note(A, 21, 1);
        run_n(exp_q.size() - 1, 1'b1, 1'b0, 1'b0);
        cycle_chk(1'b0, 1'b0, 1'b0);
        push_idle(2);
        run_n(2, 1'b0, 1'b0, 1'b0);

        tag = "same_cycle";
        push_idle(1);
        cycle_chk(1'b1, 1'b1, 1'b0);
        push_sil(A, 1);
        push_note(A, 24, 2);
        run_n(exp_q.size() - 1, 1'b1, 1'b0, 1'b0);
        cycle_chk(1'b0, 1'b0, 1'b0);
        push_idle(2);
        run_n(2, 1'b0, 1'b0, 1'b0);

        tag = "stop_vs_req";
        push_idle(5);
        cycle_chk(1'b0, 1'b1, 1'b1);
        cycle_chk(1'b1, 1'b0, 1'b1);
        cycle_chk(1'b1, 1'b0, 1'b0);
        cycle_chk(1'b0, 1'b0, 1'b0);
        cycle_chk(1'b0, 1'b0, 1'b0);

        tag = "reset_mid";
        push_idle(1);
        cycle_chk(1'b0, 1'b1, 1'b0);
        push_sil(C, 1);
        push_note(C, 12, 3);
        run_n(exp_q.size(), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        push_note(C, 12, 1);
        cycle_chk(1'b0, 1'b0, 1'b0);
        push_idle(1);
        cycle_chk(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tag = "chime_after_reset";
        push_idle(1);
        cycle_chk(1'b0, 1'b1, 1'b0);
        exp_chime();
        run_n(exp_q.size(), 1'b0, 1'b0, 1'b0);
        push_idle(2);
        run_n(2, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
